multi_lane_mac_engine: RTL and testbench
========================================

Name: multi_lane_mac_engine

Overview:
- Parametrised successor to the single-lane multi-precision MAC: NUM_LANES parallel 8-bit lanes per beat, reduced and accumulated into one signed accumulator.
- Adds a run-time operation count, valid/ready handshakes on input and output, packed dual-INT4 lanes, an unsigned INT8 mode, and selectable saturation with a sticky overflow flag.
- Sits between the operand streamer and the requantisation stage of the inference datapath.

Parameters:
- NUM_LANES, 4, number of 8-bit operand lanes per beat (>=1).
- ACC_WIDTH, 32, accumulator width in bits (>=20).
- MAX_OPS, 256, largest allowed cfg_num_ops. Derived localparam CNT_W = $clog2(MAX_OPS+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort. Returns to IDLE and zeroes all state. Lower priority than rst.
- cfg_mode  in  2  00 INT8 signed, 01 INT4 signed packed (two nibbles per byte), 10 INT8 unsigned, 11 reserved (treated as 00).
- cfg_num_ops  in  CNT_W  beats to accumulate. Sampled on start.
- cfg_saturate  in  1  1 = clamp on overflow, 0 = wrap. Sampled on start.
- start  in  1  begin an operation. Honoured only in IDLE.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts a beat.
- in_a  in  8*NUM_LANES  lane k = bits [8k+7:8k].
- in_b  in  8*NUM_LANES  same packing as in_a.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_WIDTH  signed final accumulator.
- out_overflow  out  1  sticky: overflow occurred during the operation.
- out_count  out  CNT_W  beats actually accumulated.

Behaviour:
- Reset (rst=1 at an edge):
  - state = IDLE.
  - Outputs: busy=0, in_ready=0, out_valid=0, out_acc=0, out_overflow=0, out_count=0.
  - Pipeline registers and counters cleared.
- FSM states: IDLE, ACCUM, DRAIN, HOLD.
  - IDLE to ACCUM on start. The edge latches cfg_*, sets acc=0 and remaining=cfg_num_ops. If cfg_num_ops=0, go to HOLD instead, with out_acc=0 and out_count=0.
  - ACCUM: in_ready = (remaining != 0).
    - A beat is accepted when in_valid && in_ready; each accepted beat decrements remaining.
    - When the last beat is accepted, go to DRAIN.
    - in_valid gaps are allowed and stall only the input side.
  - DRAIN: waits two cycles for the pipeline to empty, then goes to HOLD.
  - HOLD: out_valid=1 and out_acc, out_overflow, out_count stay stable. On out_valid && out_ready, go to IDLE. start is ignored in HOLD.
- Pipeline:
  - Stage 1 registers the per-lane products plus the lane reduction tree.
  - Stage 2 adds the beat sum into the accumulator.
  - Latency: out_valid rises on the 3rd edge after the edge that accepts the last beat.
  - Throughput: 1 beat/cycle.
- Per-lane arithmetic:
  - INT8 signed: sext(a) * sext(b), 16-bit signed.
  - INT8 unsigned: a * b, zero-extended to 17 bits signed.
  - INT4 packed: sext(a[3:0])*sext(b[3:0]) + sext(a[7:4])*sext(b[7:4]). Range -112..128.
  - Beat sum is held at 17+$clog2(NUM_LANES) bits signed.
- Accumulation:
  - Computed at ACC_WIDTH+1 bits. Overflow = result outside the signed ACC_WIDTH range.
  - On overflow, out_overflow is set sticky.
  - cfg_saturate=1: clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), and keep accumulating from the clamped value.
  - cfg_saturate=0: two's-complement wrap.
- clear, in any state, at an edge:
  - Goes to IDLE and zeroes acc, counters, the pipeline and all outputs.
  - Any in-flight beats are discarded and no out_valid is produced.
- Precedence:
  - rst beats clear; clear beats start.
  - If clear and out_ready arrive in the same HOLD cycle, the result counts as dropped; consumers must not count it.
- No combinational path from in_valid to in_ready. out_valid depends on state only.

Test Plan:
- INT8 signed, num_ops=8, all lanes a=10, b=5 -> out_acc=1600, out_overflow=0, out_count=8, out_valid 3 edges after the last accept.
- INT4 packed, num_ops=4, all lanes a=0x73, b=0x25 -> 116 per beat, out_acc=464. Then a=b=0x88 for 2 beats -> out_acc=1024.
- INT8 unsigned, num_ops=2, all lanes 0xFF x 0xFF -> out_acc=520200, out_overflow=0.
- Bench instance with ACC_WIDTH=20, INT8 signed, all lanes -128 x -128, num_ops=8:
  - cfg_saturate=1 -> out_acc=524287, out_overflow=1.
  - cfg_saturate=0 -> out_acc=-524288, out_overflow=1.
- Backpressure, INT8 signed, num_ops=6, all lanes a=3, b=-2: in_valid dropped on alternate cycles and out_ready held low 5 cycles in HOLD.
  - out_acc=-144, stable throughout HOLD.
  - start pulses during HOLD are ignored.
  - busy falls the edge after the out_ready handshake.
- clear asserted after 3 of 8 beats -> IDLE the next cycle, out_valid never rises.
- Follow-up with num_ops=0 -> HOLD with out_acc=0 and out_count=0, and no residue from the aborted operation.

Source files
------------

// File: rtl/multi_lane_mac_engine.sv
// multi_lane_mac_engine
//   Multi-lane multiply-accumulate engine. Each accepted beat carries NUM_LANES
//   8-bit operand pairs. The lanes are multiplied (INT8 signed, dual packed INT4
//   signed, or INT8 unsigned) and reduced to one beat sum. The beat sum is then
//   added into a signed ACC_WIDTH accumulator, which either wraps or saturates
//   on overflow. The result is held until the consumer takes it.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   clear               synchronous abort back to IDLE, zeroes all state
//   cfg_mode            00 INT8 s, 01 INT4 s packed, 10 INT8 u, 11 as 00
//   cfg_num_ops         beats to accumulate (sampled on start)
//   cfg_saturate        1 clamp, 0 wrap (sampled on start)
//   start, busy         operation launch (IDLE only) / engine not idle
//   in_valid, in_ready  operand beat handshake; in_a/in_b lane k = [8k+7:8k]
//   out_valid/out_ready result handshake
//   out_acc             final accumulator
//   out_overflow        sticky overflow flag
//   out_count           beats accumulated
module multi_lane_mac_engine #(
  parameter int NUM_LANES = 4,
  parameter int ACC_WIDTH = 32,
  parameter int MAX_OPS   = 256,
  localparam int CNT_W    = $clog2(MAX_OPS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [1:0]             cfg_mode,
  input  logic [CNT_W-1:0]       cfg_num_ops,
  input  logic                   cfg_saturate,
  input  logic                   start,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_LANES-1:0] in_a,
  input  logic [8*NUM_LANES-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_acc,
  output logic                   out_overflow,
  output logic [CNT_W-1:0]       out_count
);

  localparam int SUM_W = 17 + $clog2(NUM_LANES);
  // Extended width for the accumulate: at least ACC_WIDTH+1, and wide enough
  // that a large lane count cannot truncate the beat sum.
  localparam int EXT_W = (ACC_WIDTH + 1 > SUM_W) ? ACC_WIDTH + 1 : SUM_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q;
  logic                   sat_q;
  logic [CNT_W-1:0]       rem_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   pv_q;
  logic signed [SUM_W-1:0] bsum_d, bsum_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                   ovf_q, ovf_now;
  logic [1:0]             drain_q;
  logic [ACC_WIDTH-1:0]   out_acc_q;
  logic                   out_ovf_q;
  logic [CNT_W-1:0]       out_cnt_q;

  logic signed [EXT_W-1:0]       sum_ext;
  logic [EXT_W-ACC_WIDTH:0]      sum_top;
  logic                          start_fire;
  logic                          accept;

  // One lane: both packed INT4 halves share the same multiply-add form, so the
  // 8-bit modes just leave the second product at zero.
  function automatic logic signed [16:0] lane_product(input logic [1:0] mode,
                                                      input logic [7:0] a,
                                                      input logic [7:0] b);
    logic signed [16:0] x0, y0, x1, y1;
    x1 = '0;
    y1 = '0;
    case (mode)
      2'b01: begin
        x0 = 17'($signed(a[3:0]));
        y0 = 17'($signed(b[3:0]));
        x1 = 17'($signed(a[7:4]));
        y1 = 17'($signed(b[7:4]));
      end
      2'b10: begin
        x0 = 17'(a);
        y0 = 17'(b);
      end
      default: begin
        x0 = 17'($signed(a));
        y0 = 17'($signed(b));
      end
    endcase
    return x0 * y0 + x1 * y1;
  endfunction

  assign start_fire = (state_q == S_IDLE) && start;
  assign accept     = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = (cfg_num_ops == '0) ? S_HOLD : S_ACCUM;
        S_ACCUM: if (accept && rem_q == CNT_W'(1)) state_d = S_DRAIN;
        S_DRAIN: if (drain_q == 2'd2) state_d = S_HOLD;
        S_HOLD:  if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state only
  always_comb begin
    busy      = (state_q != S_IDLE);
    in_ready  = (state_q == S_ACCUM) && (rem_q != '0);
    out_valid = (state_q == S_HOLD);
  end

  // Lane reduction
  always_comb begin
    bsum_d = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      bsum_d = bsum_d + SUM_W'(lane_product(mode_q, in_a[8*k +: 8], in_b[8*k +: 8]));
    end
  end

  // Accumulate with overflow detection: the result fits ACC_WIDTH only when
  // all bits from the ACC_WIDTH sign bit upward agree.
  always_comb begin
    sum_ext = EXT_W'(acc_q) + EXT_W'(bsum_q);
    sum_top = sum_ext[EXT_W-1:ACC_WIDTH-1];
    ovf_now = (sum_top != '0) && (sum_top != '1);
    acc_d   = sum_ext[ACC_WIDTH-1:0];
    if (ovf_now && sat_q) begin
      acc_d = sum_ext[EXT_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  // Datapath: stage 1 = beat sum register, stage 2 = accumulator
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mode_q    <= '0;
      sat_q     <= 1'b0;
      rem_q     <= '0;
      cnt_q     <= '0;
      pv_q      <= 1'b0;
      bsum_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      drain_q   <= '0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
      out_cnt_q <= '0;
    end else if (start_fire) begin
      mode_q    <= cfg_mode;
      sat_q     <= cfg_saturate;
      rem_q     <= cfg_num_ops;
      cnt_q     <= '0;
      pv_q      <= 1'b0;
      bsum_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      drain_q   <= '0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      pv_q <= accept;
      if (accept) begin
        bsum_q <= bsum_d;
        rem_q  <= rem_q - CNT_W'(1);
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (pv_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_q | ovf_now;
      end
      drain_q <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;
      // The accumulator is final one edge after the last accept; the result
      // registers are loaded on the edge that enters HOLD.
      if (state_q == S_DRAIN && drain_q == 2'd2) begin
        out_acc_q <= acc_q;
        out_ovf_q <= ovf_q;
        out_cnt_q <= cnt_q;
      end
    end
  end

  assign out_acc      = out_acc_q;
  assign out_overflow = out_ovf_q;
  assign out_count    = out_cnt_q;

endmodule

// File: tb/tb_multi_lane_mac_engine.sv
// Directed bench for multi_lane_mac_engine. A 32-bit and a 20-bit accumulator
// instance share the same stimulus; the 20-bit one exercises overflow.
module tb_multi_lane_mac_engine;

  localparam int NL = 4;
  localparam int CW = $clog2(256 + 1);

  logic          clk = 1'b0;
  logic          rst, clear, start, in_valid, out_ready, cfg_saturate;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_num_ops;
  logic [8*NL-1:0] in_a, in_b;

  logic          busy, in_ready, out_valid, out_overflow;
  logic [31:0]   out_acc;
  logic [CW-1:0] out_count;
  logic          busy20, in_ready20, out_valid20, out_overflow20;
  logic [19:0]   out_acc20;
  logic [CW-1:0] out_count20;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_lane_mac_engine #(.NUM_LANES(NL), .ACC_WIDTH(32), .MAX_OPS(256)) dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_mode(cfg_mode),
    .cfg_num_ops(cfg_num_ops), .cfg_saturate(cfg_saturate), .start(start),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_overflow(out_overflow), .out_count(out_count)
  );

  multi_lane_mac_engine #(.NUM_LANES(NL), .ACC_WIDTH(20), .MAX_OPS(256)) dut20 (
    .clk(clk), .rst(rst), .clear(clear), .cfg_mode(cfg_mode),
    .cfg_num_ops(cfg_num_ops), .cfg_saturate(cfg_saturate), .start(start),
    .busy(busy20), .in_valid(in_valid), .in_ready(in_ready20), .in_a(in_a),
    .in_b(in_b), .out_valid(out_valid20), .out_ready(out_ready),
    .out_acc(out_acc20), .out_overflow(out_overflow20), .out_count(out_count20)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] mode, input int n, input logic sat);
    cfg_mode     = mode;
    cfg_num_ops  = CW'(n);
    cfg_saturate = sat;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Returns at #1 after the edge that accepted the n-th beat.
  task automatic feed(input int n, input logic [7:0] a, input logic [7:0] b, input bit gappy);
    int got = 0;
    int cyc = 0;
    bit ph = 1'b0;
    in_a = {NL{a}};
    in_b = {NL{b}};
    while (got < n && cyc < 200) begin
      in_valid = gappy ? ph : 1'b1;
      ph = !ph;
      if (in_valid && in_ready) got++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (got < n) check_eq("feed_timeout", got, n);
  endtask

  // Called right after the last accepting edge; out_valid must rise on the
  // third edge after it.
  task automatic expect_result(input string tag, input longint acc, input int cnt, input bit ovf);
    check_eq({tag, "_in_ready_after_last"}, in_ready, 0);
    check_eq({tag, "_valid_e0"}, out_valid, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq($sformatf("%s_valid_e%0d", tag, k), out_valid, (k == 3) ? 1 : 0);
    end
    check_eq({tag, "_acc"}, longint'($signed(out_acc)), acc);
    check_eq({tag, "_count"}, out_count, cnt);
    check_eq({tag, "_ovf"}, out_overflow, ovf);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_busy_after_take"}, busy, 0);
    check_eq({tag, "_valid_after_take"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; clear = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_mode = '0; cfg_num_ops = '0; cfg_saturate = 1'b0; in_a = '0; in_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_acc", out_acc, 0);
    check_eq("rst_out_ovf", out_overflow, 0);
    check_eq("rst_out_count", out_count, 0);

    // INT8 signed: 4 lanes x 50 x 8 beats
    start_op(2'b00, 8, 1'b0);
    check_eq("s8_busy", busy, 1);
    feed(8, 8'd10, 8'd5, 1'b0);
    expect_result("s8", 1600, 8, 1'b0);
    release_result("s8");

    // INT4 packed: (3*5 + 7*2) * 4 lanes = 116 per beat
    start_op(2'b01, 4, 1'b0);
    feed(4, 8'h73, 8'h25, 1'b0);
    expect_result("i4a", 464, 4, 1'b0);
    release_result("i4a");
    // (-8*-8)*2 * 4 lanes = 512 per beat
    start_op(2'b01, 2, 1'b0);
    feed(2, 8'h88, 8'h88, 1'b0);
    expect_result("i4b", 1024, 2, 1'b0);
    release_result("i4b");

    // INT8 unsigned: 65025 * 4 * 2
    start_op(2'b10, 2, 1'b0);
    feed(2, 8'hFF, 8'hFF, 1'b0);
    expect_result("u8", 520200, 2, 1'b0);
    release_result("u8");

    // 16384 * 4 * 8 = 524288 overflows a 20-bit accumulator on the last beat
    start_op(2'b00, 8, 1'b1);
    feed(8, 8'h80, 8'h80, 1'b0);
    expect_result("sat32", 524288, 8, 1'b0);
    check_eq("sat20_acc", longint'($signed(out_acc20)), 524287);
    check_eq("sat20_ovf", out_overflow20, 1);
    release_result("sat32");

    start_op(2'b00, 8, 1'b0);
    feed(8, 8'h80, 8'h80, 1'b0);
    expect_result("wrap32", 524288, 8, 1'b0);
    check_eq("wrap20_acc", longint'($signed(out_acc20)), -524288);
    check_eq("wrap20_ovf", out_overflow20, 1);
    release_result("wrap32");

    // Backpressure: 3 * -2 * 4 lanes * 6 beats = -144
    start_op(2'b00, 6, 1'b0);
    feed(6, 8'd3, 8'hFE, 1'b1);
    expect_result("bp", -144, 6, 1'b0);
    for (int k = 0; k < 5; k++) begin
      start = (k % 2 == 0);
      tick();
      check_eq("bp_hold_valid", out_valid, 1);
      check_eq("bp_hold_acc", longint'($signed(out_acc)), -144);
      check_eq("bp_hold_count", out_count, 6);
      check_eq("bp_hold_busy", busy, 1);
    end
    start = 1'b0;
    release_result("bp");

    // Abort after 3 of 8 beats
    start_op(2'b00, 8, 1'b0);
    feed(3, 8'd10, 8'd5, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_busy", busy, 0);
    check_eq("clr_in_ready", in_ready, 0);
    check_eq("clr_out_valid", out_valid, 0);
    seen = 0;
    repeat (6) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("clr_no_valid", seen, 0);

    // Zero-length operation goes straight to HOLD
    start_op(2'b00, 0, 1'b0);
    check_eq("z_valid", out_valid, 1);
    check_eq("z_acc", out_acc, 0);
    check_eq("z_count", out_count, 0);
    check_eq("z_ovf", out_overflow, 0);
    release_result("z");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
